fetch_stage: RTL and testbench

- Instruction fetch stage at the head of the core pipeline.
- Reads 32-bit instruction words from the instruction memory port and splits each word into a low half (opcode/registers) and an immediate half.
- Hands each instruction to the decode stage over the pipeline submit/ready handshake.
- Owns the PC: redirects it on execute flushes and, optionally, on statically predicted jumps.

---
 rtl/fetch_stage_pkg.sv | 22 ++
 rtl/fetch_predecode.sv | 18 +
 rtl/fetch_stage.sv | 139 +++++++++++++
 tb/tb_fetch_stage.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode definitions: instruction sizing, jump opcodes, fetch state encoding.
package fetch_stage_pkg;

  localparam int unsigned I_SIZE = 32;
  localparam int unsigned RW     = 16;

  localparam logic [6:0] OPC_JMP = 7'h0E;
  localparam logic [6:0] OPC_JAL = 7'h0F;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  // JAL always jumps; JMP is unconditional only when its condition field [10:7] is zero.
  function automatic logic is_static_jump(input logic [10:0] instr_lo);
    return (instr_lo[6:0] == OPC_JAL) ||
           ((instr_lo[6:0] == OPC_JMP) && (instr_lo[10:7] == 4'd0));
  endfunction

endpackage

// File: rtl/fetch_predecode.sv
// Combinational static jump predictor: taken flag and target from the fetched word.
module fetch_predecode
  import fetch_stage_pkg::*;
#(
  parameter int unsigned PC_W  = 16,
  parameter int unsigned IMM_W = 16,
  parameter bit          EN    = 1'b1
) (
  input  logic [10:0]      i_instr_lo,
  input  logic [IMM_W-1:0] i_imm,
  output logic             o_taken_c,
  output logic [PC_W-1:0]  o_target_c
);

  assign o_taken_c  = EN && is_static_jump(i_instr_lo);
  assign o_target_c = PC_W'(i_imm);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues single-outstanding memory requests,
// hands words to decode. Static jump prediction enabled by `FETCH_STATIC_PRED_EN.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     INSTR_W  = I_SIZE
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  output logic                o_mem_req,
  output logic [PC_W-1:0]     o_mem_addr,
  input  logic                i_mem_ack,
  input  logic [INSTR_W-1:0]  i_mem_data,
  output logic [RW-1:0]       o_instr_l,
  output logic [INSTR_W-17:0] o_imm_pass,
  output logic                o_jmp_pred_pass,
  output logic                o_submit,
  input  logic                i_next_ready,
  input  logic                i_flush,
  input  logic [PC_W-1:0]     i_flush_pc
);

  localparam int unsigned IMM_W = INSTR_W - RW;

`ifdef FETCH_STATIC_PRED_EN
  localparam bit PRED_EN = 1'b1;
`else
  localparam bit PRED_EN = 1'b0;
`endif

  fetch_state_e     r_state;
  logic [PC_W-1:0]  r_pc;
  logic             r_mem_req;
  logic [PC_W-1:0]  r_mem_addr;
  logic [RW-1:0]    r_instr_l;
  logic [IMM_W-1:0] r_imm;
  logic             r_pred;
  logic             r_submit;

  logic             w_taken;
  logic [PC_W-1:0]  w_target;
  logic [PC_W-1:0]  w_pc_inc;
  logic [PC_W-1:0]  w_next_pc;

  fetch_predecode #(
    .PC_W  (PC_W),
    .IMM_W (IMM_W),
    .EN    (PRED_EN)
  ) u_predecode (
    .i_instr_lo (i_mem_data[10:0]),
    .i_imm      (i_mem_data[INSTR_W-1:RW]),
    .o_taken_c  (w_taken),
    .o_target_c (w_target)
  );

  assign w_pc_inc  = r_pc + PC_W'(1);
  assign w_next_pc = w_taken ? w_target : w_pc_inc;

  // Output registers double as the holding register while decode is stalled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_FETCH;
      r_pc       <= RESET_PC;
      r_mem_req  <= 1'b0;
      r_mem_addr <= RESET_PC;
      r_instr_l  <= '0;
      r_imm      <= '0;
      r_pred     <= 1'b0;
      r_submit   <= 1'b0;
    end else begin
      r_submit <= 1'b0;
      case (r_state)
        ST_FETCH: begin
          if (i_flush) begin
            r_pc <= i_flush_pc;
            if (r_mem_req && !i_mem_ack) begin
              r_state <= ST_DISCARD;
            end else begin
              r_mem_req  <= 1'b1;
              r_mem_addr <= i_flush_pc;
            end
          end else if (!r_mem_req) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_pc;
          end else if (i_mem_ack) begin
            r_instr_l <= i_mem_data[RW-1:0];
            r_imm     <= i_mem_data[INSTR_W-1:RW];
            r_pred    <= w_taken;
            r_pc      <= w_next_pc;
            if (i_next_ready) begin
              r_submit   <= 1'b1;
              r_mem_addr <= w_next_pc;
            end else begin
              r_mem_req <= 1'b0;
              r_state   <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (i_flush) begin
            r_pc       <= i_flush_pc;
            r_mem_req  <= 1'b1;
            r_mem_addr <= i_flush_pc;
            r_state    <= ST_FETCH;
          end else if (i_next_ready) begin
            r_submit   <= 1'b1;
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_pc;
            r_state    <= ST_FETCH;
          end
        end
        ST_DISCARD: begin
          // Request stays up until its ack; the returned word is thrown away.
          if (i_flush) begin
            r_pc <= i_flush_pc;
          end
          if (i_mem_ack) begin
            r_mem_addr <= i_flush ? i_flush_pc : r_pc;
            r_state    <= ST_FETCH;
          end
        end
        default: begin
          r_state   <= ST_FETCH;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign o_mem_req       = r_mem_req;
  assign o_mem_addr      = r_mem_addr;
  assign o_instr_l       = r_instr_l;
  assign o_imm_pass      = r_imm;
  assign o_jmp_pred_pass = r_pred;
  assign o_submit        = r_submit;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage; expectations follow FETCH_STATIC_PRED_EN.
module tb_fetch_stage;

`ifdef FETCH_STATIC_PRED_EN
  localparam bit PRED = 1'b1;
`else
  localparam bit PRED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_data = '0;
  logic [15:0] instr_l;
  logic [15:0] imm_pass;
  logic        jmp_pred;
  logic        submit;
  logic        next_ready = 1'b1;
  logic        flush = 1'b0;
  logic [15:0] flush_pc = '0;

  int total = 0;
  int bad   = 0;

  fetch_stage dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .o_mem_req       (mem_req),
    .o_mem_addr      (mem_addr),
    .i_mem_ack       (mem_ack),
    .i_mem_data      (mem_data),
    .o_instr_l       (instr_l),
    .o_imm_pass      (imm_pass),
    .o_jmp_pred_pass (jmp_pred),
    .o_submit        (submit),
    .i_next_ready    (next_ready),
    .i_flush         (flush),
    .i_flush_pc      (flush_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ack;
    logic [31:0] data;
    logic        rdy;
    logic        fl;
    logic [15:0] fpc;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_sub;
    logic [15:0] e_instr;
    logic [15:0] e_imm;
    logic        e_pred;
  } vec_t;

  vec_t v[27];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ack, input logic [31:0] data, input logic rdy,
                              input logic fl, input logic [15:0] fpc, input logic e_req,
                              input logic [15:0] e_addr, input logic e_sub,
                              input logic [15:0] e_instr, input logic [15:0] e_imm,
                              input logic e_pred);
    vec_t r;
    r.ack = ack; r.data = data; r.rdy = rdy; r.fl = fl; r.fpc = fpc;
    r.e_req = e_req; r.e_addr = e_addr; r.e_sub = e_sub;
    r.e_instr = e_instr; r.e_imm = e_imm; r.e_pred = e_pred;
    return r;
  endfunction

  // Inputs are applied before the edge, outputs sampled 1 time unit after it.
  task automatic run_vec(input vec_t x, input int idx);
    mem_ack    = x.ack;
    mem_data   = x.data;
    next_ready = x.rdy;
    flush      = x.fl;
    flush_pc   = x.fpc;
    @(posedge clk);
    #1;
    chk($sformatf("v%0d req", idx), 32'(mem_req), 32'(x.e_req));
    chk($sformatf("v%0d submit", idx), 32'(submit), 32'(x.e_sub));
    if (x.e_req) chk($sformatf("v%0d addr", idx), 32'(mem_addr), 32'(x.e_addr));
    if (x.e_sub) begin
      chk($sformatf("v%0d instr_l", idx), 32'(instr_l), 32'(x.e_instr));
      chk($sformatf("v%0d imm", idx), 32'(imm_pass), 32'(x.e_imm));
      chk($sformatf("v%0d pred", idx), 32'(jmp_pred), 32'(x.e_pred));
    end
  endtask

  initial begin
    //          ack  data          rdy fl fpc       req addr      sub instr     imm       pred
    v[0]  = mk(1'b0, 32'h0,        1, 0, 16'h0,    1, 16'h0000, 0, 16'h0,    16'h0,    0);
    v[1]  = mk(1'b1, 32'h00010007, 1, 0, 16'h0,    1, 16'h0001, 1, 16'h0007, 16'h0001, 0);
    v[2]  = mk(1'b1, 32'h00010007, 1, 0, 16'h0,    1, 16'h0002, 1, 16'h0007, 16'h0001, 0);
    v[3]  = mk(1'b0, 32'h0,        1, 0, 16'h0,    1, 16'h0002, 0, 16'h0,    16'h0,    0);
    v[4]  = mk(1'b1, 32'hBEEF0033, 1, 0, 16'h0,    1, 16'h0003, 1, 16'h0033, 16'hBEEF, 0);
    v[5]  = mk(1'b1, 32'h00000001, 1, 0, 16'h0,    1, 16'h0004, 1, 16'h0001, 16'h0000, 0);
    v[6]  = mk(1'b1, 32'hCAFE1234, 1, 0, 16'h0,    1, 16'h0005, 1, 16'h1234, 16'hCAFE, 0);
    v[7]  = mk(1'b1, 32'h5A5A0042, 0, 0, 16'h0,    0, 16'h0,    0, 16'h0,    16'h0,    0);
    v[8]  = mk(1'b0, 32'h0,        0, 0, 16'h0,    0, 16'h0,    0, 16'h0,    16'h0,    0);
    v[9]  = mk(1'b0, 32'h0,        0, 0, 16'h0,    0, 16'h0,    0, 16'h0,    16'h0,    0);
    v[10] = mk(1'b0, 32'h0,        1, 0, 16'h0,    1, 16'h0006, 1, 16'h0042, 16'h5A5A, 0);
    v[11] = mk(1'b1, 32'h0000FFFF, 1, 0, 16'h0,    1, 16'h0007, 1, 16'hFFFF, 16'h0000, 0);
    v[12] = mk(1'b0, 32'h0,        1, 1, 16'h0040, 1, 16'h0007, 0, 16'h0,    16'h0,    0);
    v[13] = mk(1'b0, 32'h0,        1, 0, 16'h0,    1, 16'h0007, 0, 16'h0,    16'h0,    0);
    v[14] = mk(1'b0, 32'h0,        1, 0, 16'h0,    1, 16'h0007, 0, 16'h0,    16'h0,    0);
    v[15] = mk(1'b0, 32'h0,        1, 0, 16'h0,    1, 16'h0007, 0, 16'h0,    16'h0,    0);
    v[16] = mk(1'b1, 32'h11110022, 1, 0, 16'h0,    1, 16'h0040, 0, 16'h0,    16'h0,    0);
    v[17] = mk(1'b1, 32'h00020003, 1, 0, 16'h0,    1, 16'h0041, 1, 16'h0003, 16'h0002, 0);
    v[18] = mk(1'b1, 32'h77770005, 1, 1, 16'h0100, 1, 16'h0100, 0, 16'h0,    16'h0,    0);
    v[19] = mk(1'b1, 32'h00030004, 1, 0, 16'h0,    1, 16'h0101, 1, 16'h0004, 16'h0003, 0);
    v[20] = mk(1'b0, 32'h0,        1, 1, 16'h0010, 1, 16'h0101, 0, 16'h0,    16'h0,    0);
    v[21] = mk(1'b1, 32'h99990000, 1, 0, 16'h0,    1, 16'h0010, 0, 16'h0,    16'h0,    0);
    v[22] = mk(1'b1, 32'h0123000F, 1, 0, 16'h0,    1, PRED ? 16'h0123 : 16'h0011,
               1, 16'h000F, 16'h0123, PRED);
    v[23] = mk(1'b1, 32'h00000008, 1, 1, 16'hFFFF, 1, 16'hFFFF, 0, 16'h0,    16'h0,    0);
    v[24] = mk(1'b1, 32'h00090008, 1, 0, 16'h0,    1, 16'h0000, 1, 16'h0008, 16'h0009, 0);
    v[25] = mk(1'b1, 32'h0055008E, 1, 0, 16'h0,    1, 16'h0001, 1, 16'h008E, 16'h0055, 0);
    v[26] = mk(1'b1, 32'h0200000E, 1, 0, 16'h0,    1, PRED ? 16'h0200 : 16'h0002,
               1, 16'h000E, 16'h0200, PRED);

    // Reset values while held in reset.
    #3;
    chk("rst req", 32'(mem_req), 32'd0);
    chk("rst submit", 32'(submit), 32'd0);
    chk("rst addr", 32'(mem_addr), 32'h0000);
    chk("rst pred", 32'(jmp_pred), 32'd0);
    chk("rst instr_l", 32'(instr_l), 32'd0);
    chk("rst imm", 32'(imm_pass), 32'd0);
    #19 rst_n = 1'b1;

    for (int i = 0; i < 27; i++) run_vec(v[i], i);

    // Async reset while a request is outstanding clears outputs without a clock edge.
    mem_ack = 1'b0;
    flush   = 1'b0;
    @(posedge clk);
    #1;
    chk("pre-reset req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst req", 32'(mem_req), 32'd0);
    chk("async rst submit", 32'(submit), 32'd0);
    chk("async rst addr", 32'(mem_addr), 32'h0000);
    chk("async rst pred", 32'(jmp_pred), 32'd0);
    chk("async rst instr_l", 32'(instr_l), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(mk(1'b0, 32'h0, 1, 0, 16'h0, 1, 16'h0000, 0, 16'h0, 16'h0, 0), 100);
    run_vec(mk(1'b1, 32'h00010007, 1, 0, 16'h0, 1, 16'h0001, 1, 16'h0007, 16'h0001, 0), 101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
